// File: rtl/sequence_frame_transmitter.sv
// sequence_frame_transmitter
// Serializes a parallel payload word MSB-first as a frame: preamble,
// bit-stuffed payload and a trailing zero gap. Stuffing inserts a 0 after
// every two consecutive 1s on the line, so the receive-side "111" detector
// can only fire on the preamble.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high; in_ready is high exactly while the FSM is IDLE,
// including the single done cycle that closes a frame.
//
// Timing: out/out_valid/done are registered and show the bit chosen at the
// previous edge; the state register names the frame section currently on
// the line.
`timescale 1ns/1ps
module sequence_frame_transmitter #(
   parameter int                  DATA_W     = 8,
   parameter int                  PRE_LEN    = 3,
   parameter logic [PRE_LEN-1:0]  PREAMBLE   = 3'b111,
   parameter int                  GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
   localparam int DW = $clog2(DATA_W + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);
   localparam logic [DW-1:0] DATA_ALL = DW'(DATA_W);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

   state_t              state, state_n;
   logic [DATA_W-1:0]   shreg, shreg_n;
   logic [PRE_LEN-1:0]  pre_sr, pre_sr_n;
   logic [PW-1:0]       pre_cnt, pre_cnt_n;
   logic [DW-1:0]       data_cnt, data_cnt_n;
   logic [GW-1:0]       gap_cnt, gap_cnt_n;
   logic [1:0]          run, run_n;
   logic [1:0]          run_inc;
   logic                out_n, valid_n, done_n;
   logic                data_step;

   assign in_ready = (state == IDLE);
   assign busy     = !in_ready;
   assign run_inc  = (run == 2'd2) ? 2'd2 : run + 2'd1;

   // State, counters, shift registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shreg     <= '0;
         pre_sr    <= '0;
         pre_cnt   <= '0;
         data_cnt  <= '0;
         gap_cnt   <= '0;
         run       <= 2'd0;
         out       <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         pre_sr    <= pre_sr_n;
         pre_cnt   <= pre_cnt_n;
         data_cnt  <= data_cnt_n;
         gap_cnt   <= gap_cnt_n;
         run       <= run_n;
         out       <= out_n;
         out_valid <= valid_n;
         done      <= done_n;
      end
   end

   // Next state and the next bit to place on the line.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      pre_sr_n   = pre_sr;
      pre_cnt_n  = pre_cnt;
      data_cnt_n = data_cnt;
      gap_cnt_n  = gap_cnt;
      run_n      = run;
      out_n      = out;
      valid_n    = out_valid;
      done_n     = 1'b0;
      data_step  = 1'b0;

      case (state)
         IDLE: begin
            out_n   = 1'b0;
            valid_n = 1'b0;
            if (in_valid) begin
               state_n    = PRE;
               shreg_n    = in_data;
               pre_sr_n   = PREAMBLE << 1;
               pre_cnt_n  = '0;
               data_cnt_n = '0;
               out_n      = PREAMBLE[PRE_LEN-1];
               valid_n    = 1'b1;
               run_n      = PREAMBLE[PRE_LEN-1] ? 2'd1 : 2'd0;
            end
         end
         PRE: begin
            if (pre_cnt == PRE_LAST) begin
               state_n   = DATA;
               data_step = 1'b1;
            end else begin
               out_n     = pre_sr[PRE_LEN-1];
               pre_sr_n  = pre_sr << 1;
               pre_cnt_n = pre_cnt + 1'b1;
               run_n     = pre_sr[PRE_LEN-1] ? run_inc : 2'd0;
            end
         end
         DATA: begin
            // A pending stuff is always sent, even after the last payload bit.
            if (run == 2'd2 || data_cnt != DATA_ALL) begin
               data_step = 1'b1;
            end else if (GAP_CYCLES == 0) begin
               state_n = IDLE;
               out_n   = 1'b0;
               valid_n = 1'b0;
               done_n  = 1'b1;
               run_n   = 2'd0;
            end else begin
               state_n   = GAP;
               out_n     = 1'b0;
               gap_cnt_n = '0;
               run_n     = 2'd0;
            end
         end
         GAP: begin
            out_n = 1'b0;
            if (gap_cnt == GAP_LAST) begin
               state_n = IDLE;
               valid_n = 1'b0;
               done_n  = 1'b1;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // One payload-section cycle: stuffed 0 after two 1s, else next payload bit.
      if (data_step) begin
         if (run == 2'd2) begin
            out_n = 1'b0;
            run_n = 2'd0;
         end else begin
            out_n      = shreg[DATA_W-1];
            shreg_n    = shreg << 1;
            data_cnt_n = data_cnt + 1'b1;
            run_n      = shreg[DATA_W-1] ? run_inc : 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_sequence_frame_transmitter.sv
// Directed bench for sequence_frame_transmitter: literal frames, back-to-back
// transfer, asynchronous abort and an exhaustive loopback through a "111"
// Mealy detector model, with expected bits queued at stimulus time.
`timescale 1ns/1ps
module tb_sequence_frame_transmitter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready, out, out_valid, busy, done;

   logic [0:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   int         det_count = 0;

   sequence_frame_transmitter dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy), .done(done)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_bits(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
   endtask

   // Reference frame: preamble 111, stuffing by trailing-ones run, 2 gap zeros.
   task automatic push_model(input logic [7:0] d, output int len);
      int ones;
      int i;
      ones = 0;
      len  = 0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(1'b1); len++; ones++;
      end
      i = 7;
      while (i >= 0 || ones >= 2) begin
         if (ones >= 2) begin
            exp_q.push_back(1'b0); ones = 0;
         end else begin
            exp_q.push_back(d[i]);
            ones = d[i] ? ones + 1 : 0;
            i--;
         end
         len++;
      end
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(1'b0); len++;
      end
   endtask

   // Capture one word at the next edge, then watch the frame until done.
   task automatic run_frame(input logic [7:0] d, input int exp_len, input string tag);
      int n, vc, rc, wt, det0;
      wt = 0;
      while (!in_ready && wt < 40) begin @(negedge clk); wt++; end
      chk({tag, "_ready_wait"}, (wt < 40), 1);
      det0 = det_count;
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0; vc = 0; rc = 0;
      while (n <= 60) begin
         in_data = 8'($urandom);
         @(negedge clk);
         n++;
         if (done) break;
         if (out_valid) vc++;
         if (in_ready) rc++;
      end
      chk({tag, "_done_cycle"}, n, exp_len + 1);
      chk({tag, "_valid_cycles"}, vc, exp_len);
      chk({tag, "_ready_while_busy"}, rc, 0);
      chk({tag, "_queue_left"}, exp_q.size(), 0);
      chk({tag, "_detections"}, det_count - det0, 1);
   endtask

   initial begin
      int l1, l2, n;
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;

      // scoreboard monitor: pops one expected bit per out_valid cycle and
      // runs an overlapping "111" Mealy detector on the line.
      fork
         begin
            logic [1:0] h;
            logic       det;
            int         pos;
            h = 2'b00; pos = 0;
            forever begin
               @(negedge clk);
               if (reset) begin
                  h = 2'b00; pos = 0;
               end else begin
                  det = out && h[1] && h[0];
                  if (out_valid) begin
                     if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
                     else chk("bit", out, exp_q.pop_front());
                     chk("det_position", det, (pos == 2));
                     if (det) det_count++;
                     pos++;
                  end else begin
                     pos = 0;
                  end
                  h = {h[0], out};
               end
            end
         end
      join_none

      // reset state
      #3;
      chk("rst_out", out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: all-zero payload
      push_bits(32'b11100000000000, 14);
      run_frame(8'h00, 14, "zeros");

      // 2: all-ones payload, worst-case stuffing
      push_bits(32'b111011011011011000, 18);
      run_frame(8'hFF, 18, "ones");

      // 3: mixed payload
      push_bits(32'b1110101100110000, 16);
      run_frame(8'hB6, 16, "b6");

      // 4: back-to-back with in_valid held high
      push_model(8'hA5, l1);
      push_model(8'h3C, l2);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      @(posedge clk);
      #1;
      in_data = 8'h3C;
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n <= 60);
      chk("b2b_first_done", n, l1 + 1);
      chk("b2b_ready_in_done", in_ready, 1);
      chk("b2b_gap_low", out_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
      chk("b2b_second_start", out_valid, 1);
      chk("b2b_second_busy", busy, 1);
      n = 1;
      do begin @(negedge clk); n++; end while (!done && n <= 60);
      chk("b2b_second_done", n, l2 + 1);
      chk("b2b_queue_left", exp_q.size(), 0);

      // 5: asynchronous reset during payload bit 3 of an 8'hFF frame
      @(negedge clk);
      push_bits(32'b111011011011011000, 18);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_out", out, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_bits_sent", exp_q.size(), 11);
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("abort_no_done_after", done, 0);
      end
      push_bits(32'b11100000000000, 14);
      run_frame(8'h00, 14, "after_abort");

      // 6: exhaustive loopback with random idle gaps
      for (int d = 0; d < 256; d++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         push_model(8'(d), l1);
         run_frame(8'(d), l1, "loop");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
